// File: rtl/alu_rtype_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_rtype_exec_ctrl
// Brief    : Multi-cycle R-type sequencer between fetch and the RF/ALU pair.
//            Optional macro ALU_EXEC_PERF_CNT_EN adds the retired-op counter.
// Revision : 1.0
// ============================================================================
module alu_rtype_exec_ctrl #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int OPRN_W = 6
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [31:0]       INSTR,
    input  logic              INSTR_VALID,
    output logic              INSTR_READY,
    output logic              RF_READ,
    output logic [REG_AW-1:0] RF_ADDR_R1,
    output logic [REG_AW-1:0] RF_ADDR_R2,
    input  logic [DATA_W-1:0] RF_DATA_R1,
    input  logic [DATA_W-1:0] RF_DATA_R2,
    output logic              RF_WRITE,
    output logic [REG_AW-1:0] RF_ADDR_W,
    output logic [DATA_W-1:0] RF_DATA_W,
    output logic [DATA_W-1:0] ALU_A,
    output logic [DATA_W-1:0] ALU_B,
    output logic [OPRN_W-1:0] ALU_OPRN,
    input  logic [DATA_W-1:0] ALU_Y,
    input  logic [DATA_W-1:0] ALU_ZERO,
    output logic              DONE,
    output logic              ZERO_FLAG,
    output logic              ILLEGAL,
    output logic [31:0]       PERF_CNT
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_LATCH = 3'd2,
        S_EXEC  = 3'd3,
        S_WB    = 3'd4
    } state_t;

    localparam logic [OPRN_W-1:0] OP_SHR = OPRN_W'(4);
    localparam logic [OPRN_W-1:0] OP_SHL = OPRN_W'(5);

    state_t              state_q;
    logic                ready_q;
    logic                rf_read_q;
    logic [REG_AW-1:0]   addr_r1_q;
    logic [REG_AW-1:0]   addr_r2_q;
    logic                rf_write_q;
    logic [REG_AW-1:0]   addr_w_q;
    logic [DATA_W-1:0]   data_w_q;
    logic [DATA_W-1:0]   alu_a_q;
    logic [DATA_W-1:0]   alu_b_q;
    logic [OPRN_W-1:0]   alu_oprn_q;
    logic                done_q;
    logic                zero_q;
    logic                illegal_q;
    logic [REG_AW-1:0]   rd_q;
    logic [4:0]          shamt_q;
    logic [OPRN_W-1:0]   oprn_q;

    logic [OPRN_W-1:0]   oprn_d;
    logic                legal_d;

    always_comb begin
        oprn_d  = '0;
        legal_d = 1'b0;
        if (INSTR[31:26] == 6'h00) begin
            legal_d = 1'b1;
            case (INSTR[5:0])
                6'h20:   oprn_d = OPRN_W'(1);
                6'h22:   oprn_d = OPRN_W'(2);
                6'h2c:   oprn_d = OPRN_W'(3);
                6'h02:   oprn_d = OP_SHR;
                6'h00:   oprn_d = OP_SHL;
                6'h24:   oprn_d = OPRN_W'(6);
                6'h25:   oprn_d = OPRN_W'(7);
                6'h27:   oprn_d = OPRN_W'(8);
                6'h2a:   oprn_d = OPRN_W'(9);
                default: legal_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= S_IDLE;
            ready_q    <= 1'b1;
            rf_read_q  <= 1'b0;
            addr_r1_q  <= '0;
            addr_r2_q  <= '0;
            rf_write_q <= 1'b0;
            addr_w_q   <= '0;
            data_w_q   <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_oprn_q <= '0;
            done_q     <= 1'b0;
            zero_q     <= 1'b0;
            illegal_q  <= 1'b0;
            rd_q       <= '0;
            shamt_q    <= '0;
            oprn_q     <= '0;
        end else begin
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (INSTR_VALID) begin
                        if (legal_d) begin
                            addr_r1_q <= INSTR[25:21];
                            addr_r2_q <= INSTR[20:16];
                            rd_q      <= INSTR[15:11];
                            shamt_q   <= INSTR[10:6];
                            oprn_q    <= oprn_d;
                            rf_read_q <= 1'b1;
                            ready_q   <= 1'b0;
                            state_q   <= S_READ;
                        end else begin
                            illegal_q <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    rf_read_q <= 1'b0;
                    state_q   <= S_LATCH;
                end
                S_LATCH: begin
                    alu_a_q    <= RF_DATA_R1;
                    alu_oprn_q <= oprn_q;
                    // Shifts take their distance from shamt, not from rt
                    if ((oprn_q == OP_SHR) || (oprn_q == OP_SHL)) begin
                        alu_b_q <= {{(DATA_W-5){1'b0}}, shamt_q};
                    end else begin
                        alu_b_q <= RF_DATA_R2;
                    end
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    data_w_q   <= ALU_Y;
                    zero_q     <= |ALU_ZERO;
                    addr_w_q   <= rd_q;
                    rf_write_q <= (rd_q != '0);
                    done_q     <= 1'b1;
                    state_q    <= S_WB;
                end
                S_WB: begin
                    rf_write_q <= 1'b0;
                    ready_q    <= 1'b1;
                    state_q    <= S_IDLE;
                end
                default: begin
                    rf_write_q <= 1'b0;
                    rf_read_q  <= 1'b0;
                    ready_q    <= 1'b1;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

`ifdef ALU_EXEC_PERF_CNT_EN
    logic [31:0] perf_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            perf_q <= '0;
        end else if (done_q) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign PERF_CNT = perf_q;
`else
    assign PERF_CNT = '0;
`endif

    assign INSTR_READY = ready_q;
    assign RF_READ     = rf_read_q;
    assign RF_ADDR_R1  = addr_r1_q;
    assign RF_ADDR_R2  = addr_r2_q;
    assign RF_WRITE    = rf_write_q;
    assign RF_ADDR_W   = addr_w_q;
    assign RF_DATA_W   = data_w_q;
    assign ALU_A       = alu_a_q;
    assign ALU_B       = alu_b_q;
    assign ALU_OPRN    = alu_oprn_q;
    assign DONE        = done_q;
    assign ZERO_FLAG   = zero_q;
    assign ILLEGAL     = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_rtype_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_rtype_exec_ctrl
// Brief    : Bench for alu_rtype_exec_ctrl with register-file and ALU models.
// Revision : 1.0
// ============================================================================
module tb_alu_rtype_exec_ctrl;

`ifdef ALU_EXEC_PERF_CNT_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] INSTR;
    logic        INSTR_VALID;
    logic        INSTR_READY;
    logic        RF_READ;
    logic [4:0]  RF_ADDR_R1, RF_ADDR_R2, RF_ADDR_W;
    logic [31:0] RF_DATA_R1, RF_DATA_R2;
    logic        RF_WRITE;
    logic [31:0] RF_DATA_W, ALU_A, ALU_B, ALU_Y, ALU_ZERO, PERF_CNT;
    logic [5:0]  ALU_OPRN;
    logic        DONE, ZERO_FLAG, ILLEGAL;

    logic [31:0] rf [32];
    logic        pl_we;
    logic [4:0]  pl_addr;
    logic [31:0] pl_data;

    int vec_cnt = 0;
    int err_cnt = 0;
    int exp_cnt = 0;

    always #5 CLK = ~CLK;

    alu_rtype_exec_ctrl dut (
        .CLK(CLK), .RST(RST), .INSTR(INSTR), .INSTR_VALID(INSTR_VALID),
        .INSTR_READY(INSTR_READY), .RF_READ(RF_READ),
        .RF_ADDR_R1(RF_ADDR_R1), .RF_ADDR_R2(RF_ADDR_R2),
        .RF_DATA_R1(RF_DATA_R1), .RF_DATA_R2(RF_DATA_R2),
        .RF_WRITE(RF_WRITE), .RF_ADDR_W(RF_ADDR_W), .RF_DATA_W(RF_DATA_W),
        .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_OPRN(ALU_OPRN),
        .ALU_Y(ALU_Y), .ALU_ZERO(ALU_ZERO), .DONE(DONE),
        .ZERO_FLAG(ZERO_FLAG), .ILLEGAL(ILLEGAL), .PERF_CNT(PERF_CNT)
    );

    // Register file: combinational read, clocked write
    assign RF_DATA_R1 = rf[RF_ADDR_R1];
    assign RF_DATA_R2 = rf[RF_ADDR_R2];
    always @(posedge CLK) begin
        if (RF_WRITE) rf[RF_ADDR_W] <= RF_DATA_W;
        if (pl_we)    rf[pl_addr]   <= pl_data;
    end

    // ALU keyed by operation code
    always_comb begin
        ALU_Y = 32'h0;
        case (ALU_OPRN)
            6'd1: ALU_Y = ALU_A + ALU_B;
            6'd2: ALU_Y = ALU_A - ALU_B;
            6'd3: ALU_Y = ALU_A * ALU_B;
            6'd4: ALU_Y = ALU_A >> ALU_B;
            6'd5: ALU_Y = ALU_A << ALU_B;
            6'd6: ALU_Y = ALU_A & ALU_B;
            6'd7: ALU_Y = ALU_A | ALU_B;
            6'd8: ALU_Y = ~(ALU_A | ALU_B);
            6'd9: ALU_Y = ($signed(ALU_A) < $signed(ALU_B)) ? 32'd1 : 32'd0;
            default: ALU_Y = 32'h0;
        endcase
        ALU_ZERO = (ALU_Y == 32'h0) ? 32'd1 : 32'd0;
    end

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [4:0] rd,
                                       input logic [4:0] sh, input logic [5:0] fn);
        return {op, rs, rt, rd, sh, fn};
    endfunction

    // Architectural meaning of an instruction: {legal, result}
    function automatic logic [32:0] ref_exec(input logic [31:0] ins);
        logic [31:0] a, b;
        logic [4:0]  sh;
        a  = rf[ins[25:21]];
        b  = rf[ins[20:16]];
        sh = ins[10:6];
        if (ins[31:26] != 6'h00) return 33'h0;
        case (ins[5:0])
            6'h20: return {1'b1, a + b};
            6'h22: return {1'b1, a - b};
            6'h2c: return {1'b1, a * b};
            6'h02: return {1'b1, a >> sh};
            6'h00: return {1'b1, a << sh};
            6'h24: return {1'b1, a & b};
            6'h25: return {1'b1, a | b};
            6'h27: return {1'b1, ~(a | b)};
            6'h2a: return {1'b1, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0};
            default: return 33'h0;
        endcase
    endfunction

    function automatic logic [5:0] fn2oprn(input logic [5:0] fn);
        case (fn)
            6'h20: return 6'd1;
            6'h22: return 6'd2;
            6'h2c: return 6'd3;
            6'h02: return 6'd4;
            6'h00: return 6'd5;
            6'h24: return 6'd6;
            6'h25: return 6'd7;
            6'h27: return 6'd8;
            6'h2a: return 6'd9;
            default: return 6'd0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [4:0] a, input logic [31:0] d);
        pl_we = 1'b1; pl_addr = a; pl_data = d;
        @(negedge CLK);
        pl_we = 1'b0;
    endtask

    // Called at a negedge with the DUT idle; returns at the first IDLE negedge
    task automatic run_one(input logic [31:0] ins, input logic exp_legal,
                           input logic [31:0] exp_y, input logic chain,
                           input logic [31:0] nxt);
        logic [31:0] ea, eb;
        logic [5:0]  eo;
        logic [4:0]  rd;
        rd = ins[15:11];
        ea = rf[ins[25:21]];
        eb = (ins[5:0] == 6'h02 || ins[5:0] == 6'h00) ? {27'b0, ins[10:6]} : rf[ins[20:16]];
        eo = fn2oprn(ins[5:0]);
        INSTR = ins; INSTR_VALID = 1'b1;
        check("ready_before_accept", {31'b0, INSTR_READY}, 32'd1);
        @(negedge CLK);
        if (!exp_legal) begin
            check("illegal_pulse", {31'b0, ILLEGAL}, 32'd1);
            check("illegal_no_read", {31'b0, RF_READ}, 32'd0);
            check("illegal_ready", {31'b0, INSTR_READY}, 32'd1);
            INSTR_VALID = 1'b0;
            @(negedge CLK);
            check("illegal_clear", {31'b0, ILLEGAL}, 32'd0);
            check("illegal_no_write", {31'b0, RF_WRITE}, 32'd0);
            return;
        end
        check("read_strobe", {31'b0, RF_READ}, 32'd1);
        check("read_addr1", {27'b0, RF_ADDR_R1}, {27'b0, ins[25:21]});
        check("read_addr2", {27'b0, RF_ADDR_R2}, {27'b0, ins[20:16]});
        check("busy_ready", {31'b0, INSTR_READY}, 32'd0);
        INSTR = chain ? nxt : $urandom;
        @(negedge CLK);
        check("latch_read_low", {31'b0, RF_READ}, 32'd0);
        @(negedge CLK);
        check("exec_alu_a", ALU_A, ea);
        check("exec_alu_b", ALU_B, eb);
        check("exec_oprn", {26'b0, ALU_OPRN}, {26'b0, eo});
        @(negedge CLK);
        check("wb_done", {31'b0, DONE}, 32'd1);
        check("wb_write", {31'b0, RF_WRITE}, {31'b0, rd != 5'd0});
        check("wb_data", RF_DATA_W, exp_y);
        if (rd != 5'd0) check("wb_addr", {27'b0, RF_ADDR_W}, {27'b0, rd});
        check("wb_zero_flag", {31'b0, ZERO_FLAG}, {31'b0, exp_y == 32'h0});
        check("wb_ready", {31'b0, INSTR_READY}, 32'd0);
        if (chain) INSTR = nxt; else INSTR_VALID = 1'b0;
        exp_cnt++;
        @(negedge CLK);
        check("idle_done_low", {31'b0, DONE}, 32'd0);
        check("idle_write_low", {31'b0, RF_WRITE}, 32'd0);
        check("idle_read_low", {31'b0, RF_READ}, 32'd0);
        check("idle_ready", {31'b0, INSTR_READY}, 32'd1);
        check("idle_oprn_hold", {26'b0, ALU_OPRN}, {26'b0, eo});
        check("perf_cnt", PERF_CNT, PERF_EN ? exp_cnt : 32'd0);
    endtask

    // Reset while busy; rst_phase 3 = EXEC cycle, 4 = WB cycle
    task automatic reset_midop(input int rst_phase, input logic [4:0] rd);
        logic [31:0] old;
        old = rf[rd];
        INSTR = mk(6'h00, 5'd1, 5'd2, rd, 5'd0, 6'h20); INSTR_VALID = 1'b1;
        @(negedge CLK);
        INSTR_VALID = 1'b0;
        for (int p = 2; p <= rst_phase; p++) @(negedge CLK);
        if (rst_phase == 4) check("pre_reset_write", {31'b0, RF_WRITE}, 32'd1);
        #2 RST = 1'b0;
        #1;
        exp_cnt = 0;
        check("rst_write_drop", {31'b0, RF_WRITE}, 32'd0);
        check("rst_ready", {31'b0, INSTR_READY}, 32'd1);
        check("rst_done", {31'b0, DONE}, 32'd0);
        check("rst_alu_a", ALU_A, 32'd0);
        check("rst_alu_b", ALU_B, 32'd0);
        check("rst_perf", PERF_CNT, 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        check("rst_no_writeback", rf[rd], old);
        check("rst_idle_read", {31'b0, RF_READ}, 32'd0);
    endtask

    typedef struct {
        logic [31:0] instr;
        logic        legal;
        logic [31:0] y;
    } vec_t;

    vec_t tbl[12];
    logic [5:0] legal_fn[9];

    initial begin
        logic [32:0] r;
        logic [31:0] ins;

        tbl[0]  = '{mk(6'h00, 5'd1,  5'd2,  5'd3,  5'd0, 6'h20), 1'b1, 32'd12};
        tbl[1]  = '{mk(6'h00, 5'd4,  5'd5,  5'd6,  5'd0, 6'h22), 1'b1, 32'd0};
        tbl[2]  = '{mk(6'h00, 5'd4,  5'd7,  5'd9,  5'd0, 6'h22), 1'b1, 32'd93};
        tbl[3]  = '{mk(6'h00, 5'd8,  5'd0,  5'd10, 5'd1, 6'h00), 1'b1, 32'd10};
        tbl[4]  = '{mk(6'h00, 5'd4,  5'd0,  5'd11, 5'd7, 6'h02), 1'b1, 32'd0};
        tbl[5]  = '{mk(6'h00, 5'd1,  5'd2,  5'd14, 5'd0, 6'h2c), 1'b1, 32'd35};
        tbl[6]  = '{mk(6'h00, 5'd12, 5'd13, 5'd15, 5'd0, 6'h24), 1'b1, 32'h00F0_0034};
        tbl[7]  = '{mk(6'h00, 5'd12, 5'd13, 5'd16, 5'd0, 6'h25), 1'b1, 32'hFFF0_12FF};
        tbl[8]  = '{mk(6'h00, 5'd12, 5'd13, 5'd17, 5'd0, 6'h27), 1'b1, 32'h000F_ED00};
        tbl[9]  = '{mk(6'h00, 5'd12, 5'd1,  5'd18, 5'd0, 6'h2a), 1'b1, 32'd1};
        tbl[10] = '{mk(6'h00, 5'd1,  5'd2,  5'd3,  5'd0, 6'h3f), 1'b0, 32'd0};
        tbl[11] = '{mk(6'h08, 5'd1,  5'd2,  5'd3,  5'd0, 6'h20), 1'b0, 32'd0};
        legal_fn = '{6'h20, 6'h22, 6'h2c, 6'h02, 6'h00, 6'h24, 6'h25, 6'h27, 6'h2a};

        RST = 1'b0; INSTR = 32'h0; INSTR_VALID = 1'b0;
        pl_we = 1'b0; pl_addr = 5'd0; pl_data = 32'h0;
        @(negedge CLK);
        check("reset_ready", {31'b0, INSTR_READY}, 32'd1);
        check("reset_read", {31'b0, RF_READ}, 32'd0);
        check("reset_write", {31'b0, RF_WRITE}, 32'd0);
        check("reset_oprn", {26'b0, ALU_OPRN}, 32'd0);
        check("reset_done", {31'b0, DONE}, 32'd0);
        check("reset_illegal", {31'b0, ILLEGAL}, 32'd0);
        check("reset_zero", {31'b0, ZERO_FLAG}, 32'd0);
        check("reset_perf", PERF_CNT, 32'd0);
        RST = 1'b1;

        for (int i = 0; i < 32; i++) preload(5'(i), 32'h0);
        preload(5'd1, 32'd5);    preload(5'd2, 32'd7);
        preload(5'd4, 32'd100);  preload(5'd5, 32'd100);
        preload(5'd7, 32'd7);    preload(5'd8, 32'd5);
        preload(5'd12, 32'hF0F0_1234); preload(5'd13, 32'h0FF0_00FF);

        for (int i = 0; i < 12; i++) run_one(tbl[i].instr, tbl[i].legal, tbl[i].y, 1'b0, 32'h0);
        check("rf_r3_written", rf[3], 32'd12);

        // slt into r0 with a second instruction held valid behind it
        ins = mk(6'h00, 5'd4, 5'd7, 5'd19, 5'd0, 6'h20);
        run_one(mk(6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 6'h2a), 1'b1, 32'd1, 1'b1, ins);
        run_one(ins, 1'b1, 32'd107, 1'b0, 32'h0);

        for (int i = 1; i < 32; i++) preload(5'(i), $urandom);
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) != 0)
                ins = mk(6'h00, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                         legal_fn[$urandom_range(0, 8)]);
            else
                ins = $urandom;
            r = ref_exec(ins);
            run_one(ins, r[32], r[31:0], 1'b0, 32'h0);
        end

        preload(5'd20, 32'hDEAD_BEEF);
        preload(5'd21, 32'hCAFE_F00D);
        reset_midop(3, 5'd20);
        reset_midop(4, 5'd21);

        for (int i = 0; i < 3; i++) begin
            ins = tbl[i].instr;
            r = ref_exec(ins);
            run_one(ins, r[32], r[31:0], 1'b0, 32'h0);
        end
        check("perf_after_three", PERF_CNT, PERF_EN ? 32'd3 : 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
`default_nettype wire
